// File: rtl/leb128_fetch.sv
// LEB128 immediate fetch: reads a byte window from ROM and decodes one
// signed/unsigned 32/64-bit LEB128 value per request, one byte per cycle.
module leb128_fetch #(
  parameter int unsigned MEM_DEPTH = 4,
  parameter int unsigned MEM_EXTRA = 4,
  parameter bit          USE_64B   = 1'b1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [MEM_DEPTH:0]              addr,
  input  logic                            is_signed,
  input  logic                            is_64,
  output logic                            busy,
  output logic                            valid,
  output logic [63:0]                     value,
  output logic [3:0]                      length,
  output logic [MEM_DEPTH:0]              next_addr,
  output logic [1:0]                      error,
  output logic [MEM_DEPTH:0]              mem_addr,
  output logic [MEM_EXTRA-1:0]            mem_extra,
  input  logic [(2**MEM_EXTRA)*8-1:0]     mem_data,
  input  logic                            mem_error
);

  localparam int unsigned AW   = MEM_DEPTH + 1;
  localparam int unsigned WB   = 2**MEM_EXTRA;
  localparam int unsigned DW   = WB * 8;
  localparam int unsigned IW   = (MEM_EXTRA > 4) ? MEM_EXTRA : 4;
  localparam int unsigned EX32 = ((WB - 1) < 4) ? (WB - 1) : 4;
  localparam int unsigned EX64 = ((WB - 1) < 9) ? (WB - 1) : 9;

  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_MEM      = 2'd1;
  localparam logic [1:0] ERR_OVERLONG = 2'd2;
  localparam logic [1:0] ERR_NO64     = 2'd3;

  localparam logic [63:0] LO32_MASK = 64'h0000_0000_FFFF_FFFF;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DECODE, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic                  sgn_q, sgn_d;
  logic                  is64_q, is64_d;
  logic [DW-1:0]         win_q, win_d;
  logic [63:0]           acc_q, acc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  busy_q, busy_d;
  logic                  valid_q, valid_d;
  logic [63:0]           value_q, value_d;
  logic [3:0]            length_q, length_d;
  logic [AW-1:0]         next_addr_q, next_addr_d;
  logic [1:0]            error_q, error_d;
  logic [AW-1:0]         mem_addr_q, mem_addr_d;
  logic [MEM_EXTRA-1:0]  mem_extra_q, mem_extra_d;

  logic [7:0]            cur_byte;
  logic [6:0]            shamt;
  logic [6:0]            fill_sh;
  logic [6:0]            width_bits;
  logic [63:0]           acc_nx;
  logic [63:0]           fill;
  logic [31:0]           nbytes;
  logic [31:0]           maxb;
  logic                  last_byte;

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    sgn_d       = sgn_q;
    is64_d      = is64_q;
    win_d       = win_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    valid_d     = 1'b0;
    value_d     = value_q;
    length_d    = length_q;
    next_addr_d = next_addr_q;
    error_d     = error_q;
    mem_addr_d  = mem_addr_q;
    mem_extra_d = mem_extra_q;

    cur_byte   = 8'(win_q >> {idx_q, 3'b000});
    shamt      = 7'(idx_q) * 7'd7;
    fill_sh    = shamt + 7'd7;
    width_bits = is64_q ? 7'd64 : 7'd32;
    acc_nx     = acc_q | (64'(cur_byte[6:0]) << shamt);
    if (!is64_q) acc_nx = acc_nx & LO32_MASK;
    fill = ~((64'd1 << fill_sh) - 64'd1);
    if (!is64_q) fill = fill & LO32_MASK;
    nbytes    = 32'(idx_q) + 32'd1;
    maxb      = is64_q ? 32'd10 : 32'd5;
    last_byte = (nbytes == maxb) || (nbytes == WB);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (is_64 && !USE_64B) begin
            error_d     = ERR_NO64;
            value_d     = 64'd0;
            length_d    = 4'd0;
            next_addr_d = addr;
            valid_d     = 1'b1;
            state_d     = S_DONE;
          end else begin
            addr_d      = addr;
            sgn_d       = is_signed;
            is64_d      = is_64;
            mem_addr_d  = addr;
            mem_extra_d = is_64 ? MEM_EXTRA'(EX64) : MEM_EXTRA'(EX32);
            state_d     = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        win_d = mem_data;
        if (mem_error) begin
          error_d     = ERR_MEM;
          value_d     = 64'd0;
          length_d    = 4'd0;
          next_addr_d = addr_q;
          valid_d     = 1'b1;
          state_d     = S_DONE;
        end else begin
          acc_d   = 64'd0;
          idx_d   = '0;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!cur_byte[7]) begin
          // Terminating byte: sign-extend only when the value did not fill the width
          value_d = (sgn_q && cur_byte[6] && (fill_sh < width_bits)) ? (acc_nx | fill) : acc_nx;
          length_d    = 4'(nbytes);
          next_addr_d = addr_q + AW'(nbytes);
          error_d     = ERR_OK;
          valid_d     = 1'b1;
          state_d     = S_DONE;
        end else if (last_byte) begin
          value_d     = 64'd0;
          length_d    = 4'(nbytes);
          next_addr_d = addr_q + AW'(nbytes);
          error_d     = ERR_OVERLONG;
          valid_d     = 1'b1;
          state_d     = S_DONE;
        end else begin
          acc_d = acc_nx;
          idx_d = idx_q + IW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      sgn_q       <= 1'b0;
      is64_q      <= 1'b0;
      win_q       <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      value_q     <= '0;
      length_q    <= '0;
      next_addr_q <= '0;
      error_q     <= '0;
      mem_addr_q  <= '0;
      mem_extra_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      sgn_q       <= sgn_d;
      is64_q      <= is64_d;
      win_q       <= win_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      value_q     <= value_d;
      length_q    <= length_d;
      next_addr_q <= next_addr_d;
      error_q     <= error_d;
      mem_addr_q  <= mem_addr_d;
      mem_extra_q <= mem_extra_d;
    end
  end

  assign busy      = busy_q;
  assign valid     = valid_q;
  assign value     = value_q;
  assign length    = length_q;
  assign next_addr = next_addr_q;
  assign error     = error_q;
  assign mem_addr  = mem_addr_q;
  assign mem_extra = mem_extra_q;

endmodule

// File: tb/tb_leb128_fetch.sv
// Directed bench for leb128_fetch: a combinational ROM model with a bound check
// feeds the main instance; a second instance has 64-bit support disabled.
module tb_leb128_fetch;

  logic         clk;
  logic         rst;
  logic         start;
  logic [4:0]   addr;
  logic         is_signed;
  logic         is_64;
  logic         busy;
  logic         valid;
  logic [63:0]  value;
  logic [3:0]   length;
  logic [4:0]   next_addr;
  logic [1:0]   error;
  logic [4:0]   mem_addr;
  logic [3:0]   mem_extra;
  logic [127:0] mem_data;
  logic         mem_error;

  logic         start2;
  logic         busy2;
  logic         valid2;
  logic [63:0]  value2;
  logic [3:0]   length2;
  logic [4:0]   next_addr2;
  logic [1:0]   error2;
  logic [4:0]   mem_addr2;
  logic [3:0]   mem_extra2;
  logic [127:0] mem_data2;
  logic         mem_error2;

  logic [7:0]   rom [32];
  int           bound;
  int           total;
  int           passed;
  int           cyc;
  int           seen;

  leb128_fetch #(.MEM_DEPTH(4), .MEM_EXTRA(4), .USE_64B(1'b1)) dut (
    .clk(clk), .reset(rst), .start(start), .addr(addr), .is_signed(is_signed),
    .is_64(is_64), .busy(busy), .valid(valid), .value(value), .length(length),
    .next_addr(next_addr), .error(error), .mem_addr(mem_addr), .mem_extra(mem_extra),
    .mem_data(mem_data), .mem_error(mem_error)
  );

  leb128_fetch #(.MEM_DEPTH(4), .MEM_EXTRA(4), .USE_64B(1'b0)) dut_no64 (
    .clk(clk), .reset(rst), .start(start2), .addr(addr), .is_signed(is_signed),
    .is_64(is_64), .busy(busy2), .valid(valid2), .value(value2), .length(length2),
    .next_addr(next_addr2), .error(error2), .mem_addr(mem_addr2), .mem_extra(mem_extra2),
    .mem_data(mem_data2), .mem_error(mem_error2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM: byte k of the window is rom[addr+k] (wrapping); error when the window passes the bound
  always_comb begin
    mem_data = '0;
    for (int k = 0; k < 16; k++) mem_data[8*k +: 8] = rom[5'(int'(mem_addr) + k)];
  end
  assign mem_error  = (int'(mem_addr) + int'(mem_extra)) > bound;
  assign mem_data2  = '0;
  assign mem_error2 = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Request in the next cycle (cycle 0); returns at the negedge of cycle 1
  task automatic launch(input logic [4:0] a, input logic s, input logic w);
    @(negedge clk);
    addr = a; is_signed = s; is_64 = w; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Cycle index (relative to the start cycle) at which valid is seen
  task automatic wait_valid(output int c);
    c = 1;
    while (!valid && c < 40) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic run(input string tag, input logic [4:0] a, input logic s, input logic w,
                     input logic [63:0] ev, input logic [3:0] el, input logic [4:0] en,
                     input logic [1:0] ee, input int lat);
    int c;
    launch(a, s, w);
    wait_valid(c);
    check({tag, ".lat"}, 64'(c), 64'(lat));
    check({tag, ".err"}, 64'(error), 64'(ee));
    check({tag, ".len"}, 64'(length), 64'(el));
    if (ee == 2'd0) begin
      check({tag, ".val"}, value, ev);
      check({tag, ".next"}, 64'(next_addr), 64'(en));
    end
    @(negedge clk);
    check({tag, ".pulse"}, 64'(valid), 64'd0);
  endtask

  initial begin
    total = 0; passed = 0; bound = 31;
    rst = 1'b1; start = 1'b0; start2 = 1'b0; addr = '0; is_signed = 1'b0; is_64 = 1'b0;
    for (int k = 0; k < 32; k++) rom[k] = 8'h00;
    rom[0] = 8'h03;
    rom[1] = 8'hE5; rom[2] = 8'h8E; rom[3] = 8'h26;
    rom[4] = 8'h7F;
    rom[5] = 8'h80; rom[6] = 8'h80; rom[7] = 8'h80; rom[8] = 8'h80; rom[9] = 8'h80; rom[10] = 8'h00;
    rom[11] = 8'hC0; rom[12] = 8'hBB; rom[13] = 8'h78;
    rom[30] = 8'h81; rom[31] = 8'h01;

    repeat (3) @(negedge clk);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.valid", 64'(valid), 64'd0);
    check("rst.value", value, 64'd0);
    check("rst.len", 64'(length), 64'd0);
    check("rst.next", 64'(next_addr), 64'd0);
    check("rst.err", 64'(error), 64'd0);
    check("rst.maddr", 64'(mem_addr), 64'd0);
    check("rst.mextra", 64'(mem_extra), 64'd0);
    rst = 1'b0;

    run("one_byte", 5'd0, 1'b1, 1'b1, 64'd3, 4'd1, 5'd1, 2'd0, 3);
    check("one_byte.mextra", 64'(mem_extra), 64'd9);
    run("u32_624485", 5'd1, 1'b0, 1'b0, 64'h98765, 4'd3, 5'd4, 2'd0, 5);
    check("u32.maddr", 64'(mem_addr), 64'd1);
    check("u32.mextra", 64'(mem_extra), 64'd4);
    run("s32_7f", 5'd4, 1'b1, 1'b0, 64'h0000_0000_FFFF_FFFF, 4'd1, 5'd5, 2'd0, 3);
    run("s64_7f", 5'd4, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'd1, 5'd5, 2'd0, 3);
    run("u32_7f", 5'd4, 1'b0, 1'b0, 64'h7F, 4'd1, 5'd5, 2'd0, 3);
    run("overlong", 5'd5, 1'b0, 1'b0, 64'd0, 4'd5, 5'd10, 2'd2, 7);
    run("s64_neg", 5'd11, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFE_1DC0, 4'd3, 5'd14, 2'd0, 5);
    bound = 63;
    run("wrap", 5'd30, 1'b0, 1'b0, 64'd129, 4'd2, 5'd0, 2'd0, 4);
    bound = 2;
    run("mem_err", 5'd0, 1'b0, 1'b0, 64'd0, 4'd0, 5'd0, 2'd1, 2);
    bound = 31;

    // 64-bit request on the instance without 64-bit support
    @(negedge clk);
    addr = 5'd7; is_64 = 1'b1; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    cyc = 1;
    while (!valid2 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("no64.lat", 64'(cyc), 64'd1);
    check("no64.err", 64'(error2), 64'd3);
    check("no64.len", 64'(length2), 64'd0);
    check("no64.next", 64'(next_addr2), 64'd7);

    // Back-to-back: start held high while busy is ignored, start after DONE accepted
    @(negedge clk);
    addr = 5'd0; is_signed = 1'b1; is_64 = 1'b1; start = 1'b1;
    @(negedge clk);
    addr = 5'd4; is_64 = 1'b0;
    check("b2b.busy", 64'(busy), 64'd1);
    wait_valid(cyc);
    check("b2b.lat1", 64'(cyc), 64'd3);
    check("b2b.val1", value, 64'd3);
    @(negedge clk);
    check("b2b.idle", 64'(busy), 64'd0);
    @(negedge clk);
    start = 1'b0;
    wait_valid(cyc);
    check("b2b.lat2", 64'(cyc), 64'd3);
    check("b2b.val2", value, 64'h0000_0000_FFFF_FFFF);
    @(negedge clk);

    // Reset during the second DECODE cycle
    launch(5'd1, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort.busy", 64'(busy), 64'd0);
    check("abort.value", value, 64'd0);
    check("abort.len", 64'(length), 64'd0);
    check("abort.next", 64'(next_addr), 64'd0);
    check("abort.maddr", 64'(mem_addr), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (valid) seen++;
    end
    check("abort.novalid", 64'(seen), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
